// File: rtl/ws_array_feeder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ws_array_feeder_if                                              |
// | Purpose  : Weight and activation valid/ready streams into ws_array_feeder. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface ws_array_feeder_if #(
    parameter int A_H   = 16,
    parameter int WIDTH = 8
);
    logic                 w_valid;
    logic                 w_ready;
    logic [A_H*WIDTH-1:0] w_data;
    logic                 a_in_valid;
    logic                 a_in_ready;
    logic [A_H*WIDTH-1:0] a_in_data;

    modport master (
        output w_valid, w_data, a_in_valid, a_in_data,
        input  w_ready, a_in_ready
    );

    modport slave (
        input  w_valid, w_data, a_in_valid, a_in_data,
        output w_ready, a_in_ready
    );
endinterface
`default_nettype wire

// File: rtl/ws_array_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ws_array_feeder                                                 |
// | Purpose  : Job sequencer feeding weights and activation rows into the      |
// |            weight-stationary systolic array. SKEW_EN adds lane skew.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ws_array_feeder #(
    parameter int A_H       = 16,
    parameter int B_W       = 16,
    parameter int WIDTH     = 8,
    parameter int M_MAX     = 256,
    parameter int DRAIN_CYC = 2
) (
    input  wire                         clk,
    input  wire                         rst,
    input  wire                         start,
    input  wire  [$clog2(M_MAX+1)-1:0]  m_rows,
    output logic                        busy,
    output logic                        done,
    ws_array_feeder_if.slave            feed,
    output logic                        weight_wen,
    output logic [A_H*WIDTH-1:0]        weight_din,
    output logic [A_H*WIDTH-1:0]        A,
    output logic                        a_out_valid
);
    localparam int c_DW  = A_H * WIDTH;
    localparam int c_MW  = $clog2(M_MAX + 1);
    localparam int c_WCW = (B_W > 1) ? $clog2(B_W) : 1;
`ifdef SKEW_EN
    localparam int c_DRAIN_RAW = DRAIN_CYC + A_H - 1;
`else
    localparam int c_DRAIN_RAW = DRAIN_CYC;
`endif
    localparam int c_DRAIN_LEN = (c_DRAIN_RAW < 1) ? 1 : c_DRAIN_RAW;
    localparam int c_DCW       = $clog2(c_DRAIN_LEN + 1);

    localparam logic [c_WCW-1:0] c_WCNT_LAST = c_WCW'(B_W - 1);
    localparam logic [c_DCW-1:0] c_DCNT_LAST = c_DCW'(c_DRAIN_LEN - 1);
    localparam logic [c_MW-1:0]  c_M_MAX     = c_MW'(M_MAX);
    localparam logic [c_MW-1:0]  c_ROW_ONE   = c_MW'(1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LOAD_W = 3'd1;
    localparam logic [2:0] c_ST_STREAM = 3'd2;
    localparam logic [2:0] c_ST_DRAIN  = 3'd3;
    localparam logic [2:0] c_ST_FIN    = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [c_WCW-1:0] r_wcnt;
    logic [c_MW-1:0]  r_rcnt;
    logic [c_MW-1:0]  r_rows;
    logic [c_DCW-1:0] r_dcnt;

    logic             r_busy;
    logic             r_done;
    logic             r_w_ready;
    logic             r_a_ready;
    logic             r_beat_q;
    logic             r_wen;
    logic [c_DW-1:0]  r_wdin;
    logic [c_DW-1:0]  r_a_stage;
    logic             r_aval;

    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_w_ready_nxt;
    logic             w_a_ready_nxt;

    logic             w_w_beat;
    logic             w_a_beat;
    logic             w_last_w;
    logic             w_last_row;

    assign w_w_beat   = feed.w_valid & r_w_ready;
    assign w_a_beat   = feed.a_in_valid & r_a_ready;
    assign w_last_w   = (r_wcnt == c_WCNT_LAST);
    assign w_last_row = ((r_rcnt + c_ROW_ONE) == r_rows);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) w_next_state = c_ST_LOAD_W;
            end
            c_ST_LOAD_W: begin
                if (w_w_beat && w_last_w)
                    w_next_state = (r_rows != '0) ? c_ST_STREAM : c_ST_DRAIN;
            end
            c_ST_STREAM: begin
                if (w_a_beat && w_last_row) w_next_state = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                if (r_dcnt == c_DCNT_LAST) w_next_state = c_ST_FIN;
            end
            c_ST_FIN: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Readies follow the state being entered so they drop on the accepting edge;
    // done is taken from FIN so it lands on the cycle a new start can be taken.
    always_comb begin
        w_busy_nxt    = (w_next_state != c_ST_IDLE);
        w_done_nxt    = (r_state == c_ST_FIN);
        w_w_ready_nxt = (w_next_state == c_ST_LOAD_W);
        w_a_ready_nxt = (w_next_state == c_ST_STREAM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_w_ready <= 1'b0;
            r_a_ready <= 1'b0;
            r_beat_q  <= 1'b0;
            r_wen     <= 1'b0;
            r_wdin    <= '0;
            r_a_stage <= '0;
            r_aval    <= 1'b0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_w_ready <= w_w_ready_nxt;
            r_a_ready <= w_a_ready_nxt;
            // The array registers weight_din itself, so the enable trails by one.
            r_beat_q  <= w_w_beat;
            r_wen     <= r_beat_q;
            if (w_w_beat) r_wdin <= feed.w_data;
            r_a_stage <= w_a_beat ? feed.a_in_data : '0;
            r_aval    <= w_a_beat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt <= '0;
            r_rcnt <= '0;
            r_rows <= '0;
            r_dcnt <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) r_rows <= (m_rows > c_M_MAX) ? c_M_MAX : m_rows;
                    r_wcnt <= '0;
                    r_rcnt <= '0;
                    r_dcnt <= '0;
                end
                c_ST_LOAD_W: begin
                    if (w_w_beat) r_wcnt <= w_last_w ? '0 : r_wcnt + 1'b1;
                end
                c_ST_STREAM: begin
                    if (w_a_beat) r_rcnt <= w_last_row ? '0 : r_rcnt + c_ROW_ONE;
                end
                c_ST_DRAIN: begin
                    r_dcnt <= (r_dcnt == c_DCNT_LAST) ? '0 : r_dcnt + 1'b1;
                end
                default: begin
                    r_dcnt <= '0;
                end
            endcase
        end
    end

`ifdef SKEW_EN
    for (genvar j = 0; j < A_H; j++) begin : g_lane
        if (j == 0) begin : g_direct
            assign A[WIDTH-1:0] = r_a_stage[WIDTH-1:0];
        end else begin : g_chain
            logic [WIDTH-1:0] r_chain [j];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < j; k++) r_chain[k] <= '0;
                end else begin
                    r_chain[0] <= r_a_stage[j*WIDTH +: WIDTH];
                    for (int k = 1; k < j; k++) r_chain[k] <= r_chain[k-1];
                end
            end
            assign A[j*WIDTH +: WIDTH] = r_chain[j-1];
        end
    end
`else
    assign A = r_a_stage;
`endif

    assign busy            = r_busy;
    assign done            = r_done;
    assign feed.w_ready    = r_w_ready;
    assign feed.a_in_ready = r_a_ready;
    assign weight_wen      = r_wen;
    assign weight_din      = r_wdin;
    assign a_out_valid     = r_aval;
endmodule
`default_nettype wire

// File: tb/tb_ws_array_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ws_array_feeder                                              |
// | Purpose  : Self-checking bench for ws_array_feeder against a job model.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_ws_array_feeder;
    localparam int A_H       = 16;
    localparam int B_W       = 16;
    localparam int WIDTH     = 8;
    localparam int M_MAX     = 256;
    localparam int DRAIN_CYC = 2;
    localparam int DW        = A_H * WIDTH;
    localparam int MW        = $clog2(M_MAX + 1);
`ifdef SKEW_EN
    localparam int SK = 1;
`else
    localparam int SK = 0;
`endif
    localparam int DRAIN_LEN = DRAIN_CYC + SK * (A_H - 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [MW-1:0]  m_rows;
    logic           busy;
    logic           done;
    logic           weight_wen;
    logic [DW-1:0]  weight_din;
    logic [DW-1:0]  A;
    logic           a_out_valid;

    ws_array_feeder_if #(.A_H(A_H), .WIDTH(WIDTH)) feed ();

    ws_array_feeder #(
        .A_H(A_H), .B_W(B_W), .WIDTH(WIDTH), .M_MAX(M_MAX), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .m_rows(m_rows),
        .busy(busy), .done(done), .feed(feed),
        .weight_wen(weight_wen), .weight_din(weight_din),
        .A(A), .a_out_valid(a_out_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Job model: phase 0 idle, 1 loading, 2 streaming, 3 draining, 4 finishing.
    int            md = 0;
    int            w_left, r_left, d_left, m_lat;
    logic [DW-1:0] e_wdin = '0;
    bit            e_wen, beat_prev, e_done, acc_w, acc_a;
    logic [DW-1:0] rowlog [int];   // aligned row visible on A at cycle key

    int            dut_dones = 0;
    int            done_cyc = -1;
    int            a3_cyc = -1;
    bit            saw_a_ready;
    logic [DW-1:0] wv [B_W];
    logic [DW-1:0] av [$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] splat(input int v);
        logic [DW-1:0] r;
        for (int j = 0; j < A_H; j++) r[j*WIDTH +: WIDTH] = WIDTH'(v);
        return r;
    endfunction

    function automatic logic [DW-1:0] rvec();
        logic [DW-1:0] r;
        for (int j = 0; j < A_H; j++) r[j*WIDTH +: WIDTH] = WIDTH'($urandom);
        return r;
    endfunction

    function automatic logic [DW-1:0] ramp();
        logic [DW-1:0] r;
        for (int j = 0; j < A_H; j++) r[j*WIDTH +: WIDTH] = WIDTH'(j + 1);
        return r;
    endfunction

    task automatic model_edge();
        acc_w = !rst && (md == 1) && feed.w_valid;
        acc_a = !rst && (md == 2) && feed.a_in_valid;
        if (rst) begin
            md = 0; e_wdin = '0; e_wen = 0; beat_prev = 0; e_done = 0;
            rowlog.delete();
        end else begin
            e_done    = (md == 4);
            e_wen     = beat_prev;
            beat_prev = acc_w;
            if (acc_w) e_wdin = feed.w_data;
            if (acc_a) rowlog[cyc + 1] = feed.a_in_data;
            case (md)
                0: if (start) begin
                       m_lat  = (int'(m_rows) > M_MAX) ? M_MAX : int'(m_rows);
                       w_left = B_W;
                       md     = 1;
                   end
                1: if (acc_w) begin
                       w_left--;
                       if (w_left == 0) begin
                           if (m_lat > 0) begin md = 2; r_left = m_lat; end
                           else begin md = 3; d_left = DRAIN_LEN; end
                       end
                   end
                2: if (acc_a) begin
                       r_left--;
                       if (r_left == 0) begin md = 3; d_left = DRAIN_LEN; end
                   end
                3: begin d_left--; if (d_left == 0) md = 4; end
                default: md = 0;
            endcase
        end
    endtask

    task automatic check_outputs();
        logic [DW-1:0] ea;
        logic [DW-1:0] row;
        int k;
        for (int j = 0; j < A_H; j++) begin
            k = cyc - SK * j;
            row = rowlog.exists(k) ? rowlog[k] : '0;
            ea[j*WIDTH +: WIDTH] = row[j*WIDTH +: WIDTH];
        end
        chk("busy",        DW'(busy),            DW'(md != 0));
        chk("done",        DW'(done),            DW'(e_done));
        chk("w_ready",     DW'(feed.w_ready),    DW'(md == 1));
        chk("a_in_ready",  DW'(feed.a_in_ready), DW'(md == 2));
        chk("weight_wen",  DW'(weight_wen),      DW'(e_wen));
        chk("weight_din",  weight_din,           e_wdin);
        chk("A",           A,                    ea);
        chk("a_out_valid", DW'(a_out_valid),     DW'(rowlog.exists(cyc)));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        if (done === 1'b1) begin dut_dones++; done_cyc = cyc; end
        if (feed.a_in_ready === 1'b1) saw_a_ready = 1;
        if (a_out_valid === 1'b1 && A[WIDTH-1:0] === WIDTH'(3)) a3_cyc = cyc;
    endtask

    task automatic idle(input int n);
        feed.w_valid = 0; feed.a_in_valid = 0; start = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // wmode: 0 random, 1 lanes=15..0; amode: 0 random, 1 lanes=row+1, 2 lane ramp
    task automatic run_job(input int m, input int wgap, input int agap, input int wmode,
                           input int amode, input int bubble_at, input int abort_at,
                           input bit restart);
        int  sw, sa, nrows, d0;
        bit  bubbled, fin, again;
        sw = 0; sa = 0; bubbled = 0; fin = 0; again = restart;
        nrows = (m > M_MAX) ? M_MAX : m;
        for (int i = 0; i < B_W; i++) wv[i] = (wmode == 1) ? splat(B_W - 1 - i) : rvec();
        av.delete();
        for (int i = 0; i < nrows; i++)
            av.push_back((amode == 1) ? splat(i + 1) : (amode == 2) ? ramp() : rvec());
        d0 = dut_dones;
        saw_a_ready = 0;
        feed.w_valid = 1; feed.w_data = wv[0]; feed.a_in_valid = 0;
        start = 1; m_rows = MW'(m);
        cycle();
        start = 0;
        for (int t = 0; t < 3000 && !fin; t++) begin
            feed.w_valid   = (sw < B_W) && ($urandom_range(0, 99) >= wgap);
            feed.w_data    = (sw < B_W) ? wv[sw] : rvec();
            feed.a_in_valid = (sa < nrows) && ($urandom_range(0, 99) >= agap);
            if (md == 2 && sa == bubble_at && !bubbled) begin
                feed.a_in_valid = 0; bubbled = 1;
            end
            feed.a_in_data = (sa < nrows) ? av[sa] : rvec();
            if (again && md == 1 && sw >= B_W / 2) begin start = 1; again = 0; end
            if (abort_at >= 0 && md == 2 && sa == abort_at) begin
                rst = 1;
                cycle();
                rst = 0;
                idle(4);
                chk("abort_no_done", DW'(dut_dones - d0), DW'(0));
                return;
            end
            cycle();
            start = 0;
            if (acc_w) sw++;
            if (acc_a) sa++;
            if (e_done) fin = 1;
        end
        chk("job_completes", DW'(fin), DW'(1));
        idle(3);
        chk("one_done", DW'(dut_dones - d0), DW'(1));
    endtask

    initial begin
        rst = 1; start = 0; m_rows = '0;
        feed.w_valid = 0; feed.w_data = '0; feed.a_in_valid = 0; feed.a_in_data = '0;
        cycle();
        cycle();
        rst = 0;
        idle(2);

        // Continuous descending weights, then rows 1,2,(bubble),3.
        run_job(3, 0, 0, 1, 1, 2, -1, 1'b0);
        chk("done_lag", DW'(done_cyc - a3_cyc), DW'(DRAIN_LEN + 1));

        // Zero rows with a stray start during the load.
        run_job(0, 20, 0, 0, 0, -1, -1, 1'b1);
        chk("a_ready_never", DW'(saw_a_ready), DW'(0));

        // Abort after two of five rows, then a clean job.
        run_job(5, 0, 0, 0, 1, -1, 2, 1'b0);
        run_job(4, 30, 30, 0, 0, -1, -1, 1'b0);

        // Single ramp row exercises lane alignment / skew.
        run_job(1, 0, 0, 0, 2, -1, -1, 1'b0);

        // m_rows above M_MAX is clamped.
        run_job(300, 10, 25, 0, 0, -1, -1, 1'b0);

        for (int n = 0; n < 6; n++)
            run_job($urandom_range(1, 24), $urandom_range(0, 60), $urandom_range(0, 60),
                    0, 0, -1, -1, 1'($urandom_range(0, 1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ws_array_feeder.md
Name: ws_array_feeder

Overview:
- Job sequencer that drives the input side of the weight-stationary MAC systolic array.
- Accepts a weight tile and activation rows over valid/ready streams.
- Loads the B_W weight vectors into the array by shifting, then streams M activation rows into the A port.
- Flushes the array and pulses done. Sits between the tile SRAM readers and the array top.

Parameters:
A_H, 16, lanes per vector (array height, reduction dimension K)
B_W, 16, weight vectors per tile (array width N)
WIDTH, 8, bits per element
M_MAX, 256, max activation rows per job
DRAIN_CYC, 2, flush cycles after last row (array pipeline depth)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  job start pulse, sampled in IDLE only
m_rows  in  $clog2(M_MAX+1)  rows for this job, latched on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at job end
w_valid  in  1  weight beat valid
w_ready  out  1  weight beat ready
w_data  in  A_H*WIDTH  weight vector, lane j at [(j+1)*WIDTH-1:j*WIDTH]
a_in_valid  in  1  activation beat valid
a_in_ready  out  1  activation beat ready
a_in_data  in  A_H*WIDTH  activation row, same lane packing
weight_wen  out  1  array weight shift enable
weight_din  out  A_H*WIDTH  array weight vector
A  out  A_H*WIDTH  array activation vector
a_out_valid  out  1  A carries a live row, for the result collector

Behaviour:
- All outputs are registered.
- Reset: state=IDLE; busy, done, w_ready, a_in_ready, weight_wen, a_out_valid = 0; weight_din, A, skew registers and counters = 0.
- rst mid-job aborts immediately. No done pulse; the array is not flushed.
- States: IDLE, LOAD_W, STREAM, DRAIN, FIN.
- IDLE:
  - start=1 latches min(m_rows, M_MAX), sets busy, goes to LOAD_W.
  - start in any other state is ignored.
- LOAD_W:
  - w_ready=1.
  - Each beat (w_valid&&w_ready) registers w_data onto weight_din on the next edge.
  - weight_wen asserts one cycle after weight_din updates. This matches the array, which registers weight_din internally but uses weight_wen directly.
  - Exactly B_W beats are accepted, counted by wcnt 0..B_W-1.
  - weight_wen is high for exactly B_W cycles, not necessarily contiguous; it follows beat gaps.
  - Upstream sends the column B_W-1 vector first.
  - After the B_W-th beat: w_ready drops the same edge. Go to STREAM if the latched rows > 0, else DRAIN.
- STREAM:
  - a_in_ready=1.
  - On an accepted beat, A <= a_in_data and a_out_valid <= 1 on the next edge.
  - On a bubble cycle, A <= 0 and a_out_valid <= 0.
  - The row counter counts accepts. On the last accept, a_in_ready drops the same edge and the state moves to DRAIN.
- DRAIN:
  - A = 0, a_out_valid = 0.
  - Lasts DRAIN_CYC cycles (+A_H-1 with SKEW_EN), then FIN.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
  - A new start is accepted the cycle after FIN.
- weight_din holds its last value outside LOAD_W.
- No arithmetic beyond counters. Counters never wrap: wcnt is bounded by B_W, the row counter by the latched m_rows.

Optional Feature:
SKEW_EN
- Defined: lane j of A is delayed by j extra cycles through a per-lane register chain, giving the diagonal wavefront. Lane 0 has no extra delay.
  - a_out_valid follows lane 0.
  - DRAIN is extended by A_H-1 cycles so lane A_H-1 of the last row exits.
  - Zeros are shifted in during bubbles and drain.
- Undefined: all lanes are aligned, no chain registers exist, and DRAIN is DRAIN_CYC cycles.

Test Plan:
- Reset state: assert rst 2 cycles -> all outputs 0, busy=0. Then start with w_valid=1 -> w_ready=1 the cycle after start.
- Weight load, continuous: beats with every lane = k, for k=15..0 -> weight_din = k one cycle after each beat, weight_wen high for 16 consecutive cycles lagging weight_din by 1, state exits to STREAM.
- Streaming with bubble: m_rows=3, rows of 0x01/0x02/0x03 with a_in_valid low for one cycle between rows 2 and 3 -> A shows 01,02,00,03 with a_out_valid 1,1,0,1. done pulses exactly DRAIN_CYC+1 cycles after the A=03 cycle.
- m_rows=0 and start while busy: start, load 16 weights -> goes LOAD_W->DRAIN->FIN with a_in_ready never high. A second start pulse during LOAD_W is ignored: exactly one done.
- Reset mid-STREAM: rst after 2 of 5 rows -> next cycle IDLE, A=0, a_out_valid=0, busy=0, no done. A subsequent full job completes normally.
- SKEW_EN build, A_H=16: single row with lane j = j+1 -> lane j value appears on A exactly j cycles after lane 0. done is delayed by 15 extra cycles versus the non-skew build.
